// File: rtl/aclk_pkg.sv
// ---------------------------------------------------------------------------
// aclk_pkg
// Definitions shared by the alarm-clock time entry block:
//   - entry_state_t : state encoding of the entry controller
//   - *_MAX         : wrap limits of the four BCD digits
//   - CUR_*         : encoding of the cursor output
//   - wrap_inc      : BCD increment that wraps to 0 past a limit
// ---------------------------------------------------------------------------
package aclk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EDIT_H1,
    ST_EDIT_H0,
    ST_EDIT_M1,
    ST_EDIT_M0,
    ST_COMMIT
  } entry_state_t;

  localparam logic [3:0] H1_MAX    = 4'd2;
  localparam logic [3:0] H0_MAX    = 4'd9;
  localparam logic [3:0] H0_MAX_24 = 4'd3;
  localparam logic [3:0] M1_MAX    = 4'd5;
  localparam logic [3:0] M0_MAX    = 4'd9;

  localparam logic [1:0] CUR_H1 = 2'd0;
  localparam logic [1:0] CUR_H0 = 2'd1;
  localparam logic [1:0] CUR_M1 = 2'd2;
  localparam logic [1:0] CUR_M0 = 2'd3;

  // ">=" rather than "==" so a digit that is somehow above its limit
  // still returns to a legal value on the next press.
  function automatic logic [3:0] wrap_inc(input logic [3:0] d, input logic [3:0] max);
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/aclk_btn_debounce.sv
// ---------------------------------------------------------------------------
// aclk_btn_debounce
// Level debouncer for one already-synchronised push-button. The accepted
// level only follows the input after DEB_CYCLES consecutive samples that
// differ from the current accepted level, so shorter glitches vanish.
// Only instantiated when ACLK_DEBOUNCE_EN is defined.
//
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset (accepted level 0)
//   sample  : synchronised raw button level
//   level   : debounced button level
// ---------------------------------------------------------------------------
module aclk_btn_debounce #(
  parameter int DEB_CYCLES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample,
  output logic level
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CW-1:0] cnt;

  // The counter tracks how long the input has disagreed with the accepted
  // level; any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sample == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      level <= sample;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/aclk_time_entry.sv
// ---------------------------------------------------------------------------
// aclk_time_entry
// Push-button time/alarm entry controller feeding the alarm clock core.
// Four buttons are synchronised, edge-detected and used to edit four BCD
// digits one at a time; the result is handed over with a load pulse on
// LD_time or LD_alarm. Digits can never leave the legal 00:00..23:59 range.
//
// Optional feature: define ACLK_DEBOUNCE_EN to insert aclk_btn_debounce
// between each synchroniser and its edge detector (adds DEB_CYCLES latency).
// DEB_CYCLES exists as a parameter only in that build.
//
// Parameters:
//   TIMEOUT    : idle cycles in an edit state before the edit is abandoned
//   LD_PULSE   : load pulse width in clk cycles (1..15)
//   DEB_CYCLES : debounce run length (ACLK_DEBOUNCE_EN only)
//
// Ports:
//   clk, reset_n             : clock, asynchronous active-low reset
//   btn_mode                 : IDLE only, toggles time/alarm target
//   btn_edit                 : IDLE only, starts an edit
//   btn_inc                  : increments the digit under the cursor
//   btn_next                 : advances the cursor, commits from M0
//   H_in1, H_in0, M_in1, M_in0 : BCD digits for the core
//   LD_time, LD_alarm        : load pulses
//   alarm_sel                : 0 = time target, 1 = alarm target
//   editing                  : high while an edit is in progress
//   cursor                   : 0 = H1, 1 = H0, 2 = M1, 3 = M0 (0 outside edit)
// ---------------------------------------------------------------------------
module aclk_time_entry #(
  parameter int TIMEOUT    = 100,
  parameter int LD_PULSE   = 1
`ifdef ACLK_DEBOUNCE_EN
  ,
  parameter int DEB_CYCLES = 3
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_edit,
  input  logic       btn_inc,
  input  logic       btn_next,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       alarm_sel,
  output logic       editing,
  output logic [1:0] cursor
);

  import aclk_pkg::*;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  // Button bit order: 0 = mode, 1 = edit, 2 = inc, 3 = next.
  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] level;
  logic [3:0] prev;
  logic [3:0] rise;

  assign raw = {btn_next, btn_inc, btn_edit, btn_mode};

  // Two-stage synchroniser followed by the previous-level register of the
  // rising-edge detector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= level;
    end
  end

`ifdef ACLK_DEBOUNCE_EN
  for (genvar i = 0; i < 4; i++) begin : g_deb
    aclk_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .sample  (sync2[i]),
      .level   (level[i])
    );
  end
`else
  assign level = sync2;
`endif

  assign rise = level & ~prev;

  logic rise_mode, rise_edit, rise_inc, rise_next;
  assign rise_mode = rise[0];
  assign rise_edit = rise[1];
  assign rise_inc  = rise[2];
  assign rise_next = rise[3];

  entry_state_t  state;
  logic [13:0]   shadow;
  logic [TW-1:0] idle_cnt;
  logic [3:0]    pulse_cnt;
  logic          pulse_on;

  // Incremented candidates for every digit; the H0 limit drops to 3 once
  // the hour tens digit is 2 so 24..29 can never be entered.
  logic [1:0] h1_next;
  logic [3:0] h0_limit;
  logic [3:0] h0_next;
  logic [3:0] m1_next;
  logic [3:0] m0_next;

  assign h1_next  = (H_in1 >= H1_MAX[1:0]) ? 2'd0 : H_in1 + 2'd1;
  assign h0_limit = (H_in1 == H1_MAX[1:0]) ? H0_MAX_24 : H0_MAX;
  assign h0_next  = wrap_inc(H_in0, h0_limit);
  assign m1_next  = wrap_inc(M_in1, M1_MAX);
  assign m0_next  = wrap_inc(M_in0, M0_MAX);

  // Main controller. In an edit state an inc edge has priority over a
  // simultaneous next edge, and any accepted edge beats the timeout.
  // COMMIT spends one cycle with editing still high before the load
  // pulse starts, then holds the pulse for LD_PULSE cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      H_in1     <= '0;
      H_in0     <= '0;
      M_in1     <= '0;
      M_in0     <= '0;
      shadow    <= '0;
      LD_time   <= 1'b0;
      LD_alarm  <= 1'b0;
      alarm_sel <= 1'b0;
      editing   <= 1'b0;
      cursor    <= CUR_H1;
      idle_cnt  <= '0;
      pulse_cnt <= '0;
      pulse_on  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise_mode) begin
            alarm_sel <= ~alarm_sel;
          end
          if (rise_edit) begin
            shadow   <= {H_in1, H_in0, M_in1, M_in0};
            idle_cnt <= '0;
            editing  <= 1'b1;
            cursor   <= CUR_H1;
            state    <= ST_EDIT_H1;
          end
        end

        ST_EDIT_H1, ST_EDIT_H0, ST_EDIT_M1, ST_EDIT_M0: begin
          if (rise_inc) begin
            idle_cnt <= '0;
            case (state)
              ST_EDIT_H1: begin
                H_in1 <= h1_next;
                if (h1_next == H1_MAX[1:0] && H_in0 > H0_MAX_24) begin
                  H_in0 <= 4'd0;
                end
              end
              ST_EDIT_H0: H_in0 <= h0_next;
              ST_EDIT_M1: M_in1 <= m1_next;
              default:    M_in0 <= m0_next;
            endcase
          end else if (rise_next) begin
            idle_cnt <= '0;
            case (state)
              ST_EDIT_H1: begin
                state  <= ST_EDIT_H0;
                cursor <= CUR_H0;
              end
              ST_EDIT_H0: begin
                state  <= ST_EDIT_M1;
                cursor <= CUR_M1;
              end
              ST_EDIT_M1: begin
                state  <= ST_EDIT_M0;
                cursor <= CUR_M0;
              end
              default: begin
                state    <= ST_COMMIT;
                pulse_on <= 1'b0;
              end
            endcase
          end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
            {H_in1, H_in0, M_in1, M_in0} <= shadow;
            idle_cnt <= '0;
            editing  <= 1'b0;
            cursor   <= CUR_H1;
            state    <= ST_IDLE;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end

        ST_COMMIT: begin
          if (!pulse_on) begin
            pulse_on  <= 1'b1;
            editing   <= 1'b0;
            cursor    <= CUR_H1;
            pulse_cnt <= 4'(LD_PULSE - 1);
            if (alarm_sel) begin
              LD_alarm <= 1'b1;
            end else begin
              LD_time <= 1'b1;
            end
          end else if (pulse_cnt == 4'd0) begin
            pulse_on <= 1'b0;
            LD_time  <= 1'b0;
            LD_alarm <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            pulse_cnt <= pulse_cnt - 4'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aclk_time_entry.sv
// ---------------------------------------------------------------------------
// tb_aclk_time_entry
// Directed testbench for aclk_time_entry: reset state, time and alarm entry,
// digit wrap and hour clamp, simultaneous/back-to-back buttons, edit timeout,
// reset during a load pulse and (with ACLK_DEBOUNCE_EN) glitch rejection.
// ---------------------------------------------------------------------------
module tb_aclk_time_entry;

  localparam int TIMEOUT  = 100;
  localparam int LD_PULSE = 3;
`ifdef ACLK_DEBOUNCE_EN
  localparam int DEB_CYCLES = 3;
  localparam int DEB_LAT    = DEB_CYCLES;
  localparam int HOLD       = DEB_CYCLES + 2;
`else
  localparam int DEB_LAT    = 0;
  localparam int HOLD       = 1;
`endif
  localparam int GAP = 4 + 2 * DEB_LAT;

  localparam logic [3:0] B_MODE = 4'b0001;
  localparam logic [3:0] B_EDIT = 4'b0010;
  localparam logic [3:0] B_INC  = 4'b0100;
  localparam logic [3:0] B_NEXT = 4'b1000;

  logic        clk;
  logic        reset_n;
  logic [3:0]  btns;
  logic [1:0]  H_in1;
  logic [3:0]  H_in0;
  logic [3:0]  M_in1;
  logic [3:0]  M_in0;
  logic        LD_time;
  logic        LD_alarm;
  logic        alarm_sel;
  logic        editing;
  logic [1:0]  cursor;
  logic [13:0] digits;

  int compared   = 0;
  int mismatched = 0;

  assign digits = {H_in1, H_in0, M_in1, M_in0};

  aclk_time_entry #(
    .TIMEOUT    (TIMEOUT),
    .LD_PULSE   (LD_PULSE)
`ifdef ACLK_DEBOUNCE_EN
    ,
    .DEB_CYCLES (DEB_CYCLES)
`endif
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_mode  (btns[0]),
    .btn_edit  (btns[1]),
    .btn_inc   (btns[2]),
    .btn_next  (btns[3]),
    .H_in1     (H_in1),
    .H_in0     (H_in0),
    .M_in1     (M_in1),
    .M_in0     (M_in0),
    .LD_time   (LD_time),
    .LD_alarm  (LD_alarm),
    .alarm_sel (alarm_sel),
    .editing   (editing),
    .cursor    (cursor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Load-pulse monitor: counts high cycles and rising edges of each load
  // line, overlap cycles, and digit changes while a pulse is high.
  int          ld_time_hi    = 0;
  int          ld_alarm_hi   = 0;
  int          ld_time_rise  = 0;
  int          ld_alarm_rise = 0;
  int          ld_both_hi    = 0;
  int          ld_glitch     = 0;
  logic [13:0] ld_digits     = '0;
  logic        prev_t        = 1'b0;
  logic        prev_a        = 1'b0;

  always @(negedge clk) begin
    if (LD_time) ld_time_hi++;
    if (LD_alarm) ld_alarm_hi++;
    if (LD_time && LD_alarm) ld_both_hi++;
    if (LD_time && !prev_t) ld_time_rise++;
    if (LD_alarm && !prev_a) ld_alarm_rise++;
    if ((LD_time || LD_alarm) && (prev_t || prev_a) && digits !== ld_digits) ld_glitch++;
    if (LD_time || LD_alarm) ld_digits = digits;
    prev_t = LD_time;
    prev_a = LD_alarm;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic string fmt(input logic [13:0] d);
    return $sformatf("%0d%0d:%0d%0d", d[13:12], d[11:8], d[7:4], d[3:0]);
  endfunction

  task automatic press(input logic [3:0] mask);
    btns = mask;
    repeat (HOLD) @(negedge clk);
    btns = '0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic press_n(input logic [3:0] mask, input int n);
    repeat (n) press(mask);
  endtask

  task automatic do_reset();
    btns    = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Full edit from the current digits: per-digit increment counts, then
  // optionally the final next that commits.
  task automatic edit_seq(input int c1, input int c0, input int cm1, input int cm0, input bit commit);
    press(B_EDIT);
    press_n(B_INC, c1);
    press(B_NEXT);
    press_n(B_INC, c0);
    press(B_NEXT);
    press_n(B_INC, cm1);
    press(B_NEXT);
    press_n(B_INC, cm0);
    if (commit) begin
      press(B_NEXT);
      repeat (LD_PULSE + 4) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    btns    = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({digits, LD_time, LD_alarm, alarm_sel, editing, cursor} !== 20'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got digits %s ld_t %b ld_a %b sel %b edit %b cur %0d, expected all zero",
               fmt(digits), LD_time, LD_alarm, alarm_sel, editing, cursor);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    press(B_INC);
    press(B_NEXT);
    compared++;
    if ({digits, editing, cursor} !== 17'd0) begin
      mismatched++;
      $display("[TB] FAIL idle_ignores_inc_next: got digits %s edit %b cur %0d, expected 00:00 0 0",
               fmt(digits), editing, cursor);
    end
  endtask

  task automatic test_time_set();
    int t_hi, t_rise, a_hi, glitch;
    do_reset();
    t_hi = ld_time_hi; t_rise = ld_time_rise; a_hi = ld_alarm_hi; glitch = ld_glitch;
    press(B_EDIT);
    compared++;
    if (editing !== 1'b1 || cursor !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL time_edit_start: got edit %b cur %0d, expected 1 0", editing, cursor);
    end
    press(B_INC);
    press(B_NEXT);
    compared++;
    if (H_in1 !== 2'd1 || cursor !== 2'd1) begin
      mismatched++;
      $display("[TB] FAIL time_h1: got H1 %0d cur %0d, expected 1 1", H_in1, cursor);
    end
    press_n(B_INC, 7);
    press(B_NEXT);
    press_n(B_INC, 3);
    press(B_NEXT);
    press_n(B_INC, 5);
    compared++;
    if (digits !== {2'd1, 4'd7, 4'd3, 4'd5} || cursor !== 2'd3 || editing !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL time_digits_pre_commit: got %s cur %0d edit %b, expected 17:35 3 1",
               fmt(digits), cursor, editing);
    end
    press(B_NEXT);
    repeat (LD_PULSE + 4) @(negedge clk);
    compared++;
    if (ld_time_rise - t_rise !== 1 || ld_time_hi - t_hi !== LD_PULSE) begin
      mismatched++;
      $display("[TB] FAIL time_ld_pulse: got %0d pulses %0d cycles, expected 1 pulse %0d cycles",
               ld_time_rise - t_rise, ld_time_hi - t_hi, LD_PULSE);
    end
    compared++;
    if (ld_alarm_hi - a_hi !== 0) begin
      mismatched++;
      $display("[TB] FAIL time_no_alarm_ld: got %0d LD_alarm cycles, expected 0", ld_alarm_hi - a_hi);
    end
    compared++;
    if (ld_digits !== {2'd1, 4'd7, 4'd3, 4'd5} || ld_glitch - glitch !== 0) begin
      mismatched++;
      $display("[TB] FAIL time_ld_digits: got %s glitches %0d, expected 17:35 0",
               fmt(ld_digits), ld_glitch - glitch);
    end
    compared++;
    if (editing !== 1'b0 || cursor !== 2'd0 || alarm_sel !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL time_after_commit: got edit %b cur %0d sel %b, expected 0 0 0",
               editing, cursor, alarm_sel);
    end
  endtask

  task automatic test_alarm_set();
    int t_hi, a_hi, a_rise;
    do_reset();
    t_hi = ld_time_hi; a_hi = ld_alarm_hi; a_rise = ld_alarm_rise;
    press(B_MODE);
    compared++;
    if (alarm_sel !== 1'b1 || editing !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL alarm_mode_toggle: got sel %b edit %b, expected 1 0", alarm_sel, editing);
    end
    edit_seq(2, 3, 5, 9, 1'b1);
    compared++;
    if (ld_alarm_rise - a_rise !== 1 || ld_alarm_hi - a_hi !== LD_PULSE) begin
      mismatched++;
      $display("[TB] FAIL alarm_ld_pulse: got %0d pulses %0d cycles, expected 1 pulse %0d cycles",
               ld_alarm_rise - a_rise, ld_alarm_hi - a_hi, LD_PULSE);
    end
    compared++;
    if (ld_time_hi - t_hi !== 0 || ld_digits !== {2'd2, 4'd3, 4'd5, 4'd9}) begin
      mismatched++;
      $display("[TB] FAIL alarm_ld_digits: got LD_time cycles %0d digits %s, expected 0 23:59",
               ld_time_hi - t_hi, fmt(ld_digits));
    end
    compared++;
    if (alarm_sel !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL alarm_sel_kept: got %b, expected 1", alarm_sel);
    end
  endtask

  task automatic test_wrap_clamp();
    logic [3:0] exp_h0;
    do_reset();
    edit_seq(0, 8, 0, 0, 1'b1);
    press(B_EDIT);
    press(B_INC);
    compared++;
    if (H_in1 !== 2'd1 || H_in0 !== 4'd8) begin
      mismatched++;
      $display("[TB] FAIL clamp_h1_to_1: got H1 %0d H0 %0d, expected 1 8", H_in1, H_in0);
    end
    press(B_INC);
    compared++;
    if (H_in1 !== 2'd2 || H_in0 !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL clamp_h1_to_2: got H1 %0d H0 %0d, expected 2 0", H_in1, H_in0);
    end
    press(B_NEXT);
    for (int i = 1; i <= 4; i++) begin
      press(B_INC);
      exp_h0 = (i == 4) ? 4'd0 : 4'(i);
      compared++;
      if (H_in0 !== exp_h0) begin
        mismatched++;
        $display("[TB] FAIL wrap_h0_step%0d: got %0d, expected %0d", i, H_in0, exp_h0);
      end
    end
    press(B_NEXT);
    press_n(B_INC, 5);
    compared++;
    if (M_in1 !== 4'd5) begin
      mismatched++;
      $display("[TB] FAIL wrap_m1_at5: got %0d, expected 5", M_in1);
    end
    press(B_INC);
    compared++;
    if (M_in1 !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL wrap_m1_to0: got %0d, expected 0", M_in1);
    end
    press(B_NEXT);
    press_n(B_INC, 10);
    compared++;
    if (M_in0 !== 4'd0 || cursor !== 2'd3) begin
      mismatched++;
      $display("[TB] FAIL wrap_m0_10: got M0 %0d cur %0d, expected 0 3", M_in0, cursor);
    end
    press(B_NEXT);
    repeat (LD_PULSE + 4) @(negedge clk);
    compared++;
    if (ld_digits !== {2'd2, 4'd0, 4'd0, 4'd0}) begin
      mismatched++;
      $display("[TB] FAIL wrap_commit_digits: got %s, expected 20:00", fmt(ld_digits));
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    press(B_MODE | B_EDIT);
    compared++;
    if (alarm_sel !== 1'b1 || editing !== 1'b1 || cursor !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL mode_edit_simul: got sel %b edit %b cur %0d, expected 1 1 0",
               alarm_sel, editing, cursor);
    end
    press(B_MODE);
    press(B_EDIT);
    compared++;
    if (alarm_sel !== 1'b1 || editing !== 1'b1 || cursor !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL edit_ignores_mode_edit: got sel %b edit %b cur %0d, expected 1 1 0",
               alarm_sel, editing, cursor);
    end
    press(B_INC | B_NEXT);
    compared++;
    if (H_in1 !== 2'd1 || cursor !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL inc_next_simul: got H1 %0d cur %0d, expected 1 0", H_in1, cursor);
    end
  endtask

  task automatic test_back_to_back();
    // Continues in EDIT_H1 with H1 = 1 from the previous task.
    btns = B_INC;
    @(negedge clk);
    btns = B_INC | B_NEXT;
    repeat (HOLD - 1) @(negedge clk);
    btns = B_NEXT;
    @(negedge clk);
    btns = '0;
    repeat (GAP + 1) @(negedge clk);
    compared++;
    if (H_in1 !== 2'd2 || cursor !== 2'd1) begin
      mismatched++;
      $display("[TB] FAIL back_to_back: got H1 %0d cur %0d, expected 2 1", H_in1, cursor);
    end
  endtask

  task automatic test_timeout();
    int t_hi, a_hi, n;
    do_reset();
    edit_seq(1, 2, 3, 4, 1'b1);
    t_hi = ld_time_hi; a_hi = ld_alarm_hi;
    press(B_EDIT);
    press(B_NEXT);
    press_n(B_INC, 3);
    compared++;
    if (digits !== {2'd1, 4'd5, 4'd3, 4'd4} || editing !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL timeout_pre_edit: got %s edit %b, expected 15:34 1", fmt(digits), editing);
    end
    n = 0;
    while (editing === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (n !== TIMEOUT + 3 + DEB_LAT - HOLD - GAP) begin
      mismatched++;
      $display("[TB] FAIL timeout_latency: got %0d cycles, expected %0d", n, TIMEOUT + 3 + DEB_LAT - HOLD - GAP);
    end
    compared++;
    if (digits !== {2'd1, 4'd2, 4'd3, 4'd4} || cursor !== 2'd0 || editing !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL timeout_restore: got %s cur %0d edit %b, expected 12:34 0 0",
               fmt(digits), cursor, editing);
    end
    repeat (4) @(negedge clk);
    compared++;
    if (ld_time_hi - t_hi !== 0 || ld_alarm_hi - a_hi !== 0) begin
      mismatched++;
      $display("[TB] FAIL timeout_no_load: got LD_time %0d LD_alarm %0d cycles, expected 0 0",
               ld_time_hi - t_hi, ld_alarm_hi - a_hi);
    end
  endtask

  task automatic test_reset_mid_commit();
    bit found;
    do_reset();
    edit_seq(1, 7, 3, 5, 1'b0);
    btns = B_NEXT;
    repeat (HOLD) @(negedge clk);
    btns = '0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (LD_time === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    compared++;
    if (found !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_commit_pulse_seen: got %b, expected 1", found);
    end
    reset_n = 1'b0;
    #1;
    compared++;
    if ({digits, LD_time, LD_alarm, alarm_sel, editing, cursor} !== 20'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_commit: got digits %s ld_t %b ld_a %b sel %b edit %b cur %0d, expected all zero",
               fmt(digits), LD_time, LD_alarm, alarm_sel, editing, cursor);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

`ifdef ACLK_DEBOUNCE_EN
  task automatic test_debounce();
    do_reset();
    press(B_EDIT);
    btns = B_INC;
    repeat (2) @(negedge clk);
    btns = '0;
    repeat (GAP) @(negedge clk);
    compared++;
    if (H_in1 !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL debounce_glitch: got H1 %0d, expected 0", H_in1);
    end
    press(B_INC);
    compared++;
    if (H_in1 !== 2'd1) begin
      mismatched++;
      $display("[TB] FAIL debounce_press: got H1 %0d, expected 1", H_in1);
    end
  endtask
`endif

  initial begin
    btns    = '0;
    reset_n = 1'b0;
    $display("[TB] starting aclk_time_entry bench");
    test_reset();
    test_time_set();
    test_alarm_set();
    test_wrap_clamp();
    test_simultaneous();
    test_back_to_back();
    test_timeout();
    test_reset_mid_commit();
`ifdef ACLK_DEBOUNCE_EN
    test_debounce();
`endif
    compared++;
    if (ld_both_hi !== 0) begin
      mismatched++;
      $display("[TB] FAIL ld_exclusive: got %0d overlap cycles, expected 0", ld_both_hi);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
